// File: rtl/asic_watch_gen.sv
// rtl/asic_watch_gen.sv - BCD HH:MM:SS watch core with selectable tick source, alarm and 7-segment output
module asic_watch_gen #(
    parameter int CLK_DIV        = 32768,
    parameter int SECONDS_EN     = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int ALARM_SECS     = 60,
    localparam int NDIG          = (SECONDS_EN != 0) ? 6 : 4
) (
    input  logic              sysclk_i,
    input  logic              rst_ni,
    input  logic              tick_sel_i,
    input  logic              ext_tick_i,
    input  logic              dvalid_i,
    input  logic              cfg_sel_i,
    input  logic [23:0]       cfg_i,
    input  logic              alarm_en_i,
    input  logic              alarm_ack_i,
    output logic [7*NDIG-1:0] seg_o,
    output logic [23:0]       time_o,
    output logic              sec_tick_o,
    output logic              alarm_o,
    output logic              load_err_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic [23:0]      time_q, time_d;
    logic [23:0]      alarm_reg_q, alarm_reg_d;
    logic             sec_tick_q, sec_tick_d;
    logic             alarm_q, alarm_d;
    logic             load_err_q, load_err_d;
    logic [7:0]       hold_q, hold_d;

    logic        tick_int, ext_edge, tick, cfg_ok;
    logic        time_load, alarm_load, count, fire;
    logic [23:0] time_inc;

    function automatic logic cfg_valid(input logic [23:0] v);
        logic hh_ok;
        hh_ok = (v[23:20] <= 4'd1 && v[19:16] <= 4'd9) ||
                (v[23:20] == 4'd2 && v[19:16] <= 4'd3);
        return hh_ok && (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
               (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Ripple carry across BCD digits; only legal times ever reach the registers.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) begin
                        r[15:12] = t[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        if (t[23:16] == 8'h23) begin
                            r[23:16] = 8'h00;
                        end else if (t[19:16] == 4'd9) begin
                            r[23:20] = t[23:20] + 4'd1;
                            r[19:16] = 4'd0;
                        end else begin
                            r[19:16] = t[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        tick_int   = !tick_sel_i && (div_q == DIV_MAX);
        ext_edge   = sync2_q && !hist_q;
        tick       = tick_sel_i ? ext_edge : tick_int;
        cfg_ok     = cfg_valid(cfg_i);
        time_load  = dvalid_i && !cfg_sel_i && cfg_ok;
        alarm_load = dvalid_i && cfg_sel_i && cfg_ok;
        count      = tick && !time_load;
        time_inc   = bcd_inc(time_q);
        fire       = count && alarm_en_i && (time_inc == alarm_reg_q);

        div_d = div_q;
        if (time_load) begin
            div_d = '0;
        end else if (!tick_sel_i) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        end

        // History flop tracks sync2 unconditionally so a source switch never sees a stale edge.
        sync1_d = ext_tick_i;
        sync2_d = sync1_q;
        hist_d  = sync2_q;

        time_d      = time_load ? cfg_i : (count ? time_inc : time_q);
        alarm_reg_d = alarm_load ? cfg_i : alarm_reg_q;
        sec_tick_d  = count;
        load_err_d  = dvalid_i && !cfg_ok;

        alarm_d = alarm_q;
        hold_d  = hold_q;
        if (fire) begin
            alarm_d = 1'b1;
            hold_d  = 8'(ALARM_SECS);
        end else if (!alarm_en_i || alarm_ack_i) begin
            alarm_d = 1'b0;
            hold_d  = 8'd0;
        end else if (count && alarm_q) begin
            if (hold_q <= 8'd1) begin
                alarm_d = 1'b0;
                hold_d  = 8'd0;
            end else begin
                hold_d = hold_q - 8'd1;
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (!rst_ni) begin
            div_q       <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            hist_q      <= 1'b0;
            time_q      <= 24'h0;
            alarm_reg_q <= 24'h0;
            sec_tick_q  <= 1'b0;
            alarm_q     <= 1'b0;
            load_err_q  <= 1'b0;
            hold_q      <= 8'd0;
        end else begin
            div_q       <= div_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            hist_q      <= hist_d;
            time_q      <= time_d;
            alarm_reg_q <= alarm_reg_d;
            sec_tick_q  <= sec_tick_d;
            alarm_q     <= alarm_d;
            load_err_q  <= load_err_d;
            hold_q      <= hold_d;
        end
    end

    logic [7*NDIG-1:0] seg_raw;

    if (SECONDS_EN != 0) begin : g_sec
        assign seg_raw = {seg7(time_q[23:20]), seg7(time_q[19:16]),
                          seg7(time_q[15:12]), seg7(time_q[11:8]),
                          seg7(time_q[7:4]),   seg7(time_q[3:0])};
    end else begin : g_nosec
        assign seg_raw = {seg7(time_q[23:20]), seg7(time_q[19:16]),
                          seg7(time_q[15:12]), seg7(time_q[11:8])};
    end

    assign seg_o      = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    assign time_o     = time_q;
    assign sec_tick_o = sec_tick_q;
    assign alarm_o    = alarm_q;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_asic_watch_gen.sv
// tb/tb_asic_watch_gen.sv - scoreboard bench for asic_watch_gen
module tb_asic_watch_gen;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tick_sel = 1'b1;
    logic        ext_tick = 1'b0;
    logic        dvalid = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [23:0] cfg = 24'h0;
    logic        alarm_en = 1'b0;
    logic        alarm_ack = 1'b0;
    logic [41:0] seg_o;
    logic [23:0] time_o;
    logic        sec_tick_o, alarm_o, load_err_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [23:0] model_time = 24'h0;
    logic [23:0] exp_q[$];

    asic_watch_gen #(
        .CLK_DIV(CLK_DIV), .SECONDS_EN(1), .SEG_ACTIVE_LOW(0), .ALARM_SECS(3)
    ) dut (
        .sysclk_i(clk), .rst_ni(rst_ni), .tick_sel_i(tick_sel), .ext_tick_i(ext_tick),
        .dvalid_i(dvalid), .cfg_sel_i(cfg_sel), .cfg_i(cfg), .alarm_en_i(alarm_en),
        .alarm_ack_i(alarm_ack), .seg_o(seg_o), .time_o(time_o), .sec_tick_o(sec_tick_o),
        .alarm_o(alarm_o), .load_err_o(load_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_inc(input logic [23:0] t);
        int s;
        s = (t[23:20] * 10 + t[19:16]) * 3600 + (t[15:12] * 10 + t[11:8]) * 60 +
            t[7:4] * 10 + t[3:0];
        s = (s + 1) % 86400;
        return {4'((s / 36000)), 4'((s / 3600) % 10), 4'(((s / 60) % 60) / 10),
                4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
    endfunction

    function automatic logic [41:0] exp_seg(input logic [23:0] t);
        return {seg_of(t[23:20]), seg_of(t[19:16]), seg_of(t[15:12]),
                seg_of(t[11:8]), seg_of(t[7:4]), seg_of(t[3:0])};
    endfunction

    // Scoreboard: every sec_tick_o pulse pops the time the bench predicted for it.
    always @(negedge clk) begin
        if (rst_ni && sec_tick_o) begin
            if (exp_q.size() == 0) check("unexp_tick", 48'(sec_tick_o), 48'd0);
            else check("tick_time", 48'(time_o), 48'(exp_q.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_int_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            model_time = model_inc(model_time);
            exp_q.push_back(model_time);
        end
        tick_sel = 1'b0;
        for (int c = 0; c < n * CLK_DIV; c++) begin
            cyc();
            @(negedge clk);
            check("int_tick_timing", 48'(sec_tick_o), 48'((c % CLK_DIV) == CLK_DIV - 1));
        end
        tick_sel = 1'b1;
    endtask

    task automatic do_load(input logic sel, input logic [23:0] val, input logic ok);
        cfg_sel = sel;
        cfg = val;
        dvalid = 1'b1;
        cyc();
        dvalid = 1'b0;
        if (ok && !sel) model_time = val;
        @(negedge clk);
        check("load_err", 48'(load_err_o), 48'(!ok));
        check("load_time", 48'(time_o), 48'(model_time));
        cyc();
        @(negedge clk);
        check("load_err_pulse", 48'(load_err_o), 48'd0);
    endtask

    task automatic ext_edge();
        model_time = model_inc(model_time);
        exp_q.push_back(model_time);
        ext_tick = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            @(negedge clk);
            check("ext_latency", 48'(sec_tick_o), 48'(k == 3));
        end
        ext_tick = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        repeat (3) cyc();
        @(negedge clk);
        check("rst_time", 48'(time_o), 48'h0);
        check("rst_seg", 48'(seg_o), 48'({6{7'h3F}}));
        check("rst_flags", 48'({sec_tick_o, alarm_o, load_err_o}), 48'd0);
        rst_ni = 1'b1;

        run_int_ticks(1);
        check("seg_low_digit", 48'(seg_o[6:0]), 48'h06);
        check("seg_1s", 48'(seg_o), 48'(exp_seg(model_time)));

        do_load(1'b0, 24'h235958, 1'b1);
        run_int_ticks(2);
        check("midnight_time", 48'(time_o), 48'h0);
        check("midnight_seg", 48'(seg_o), 48'({6{7'h3F}}));

        do_load(1'b0, 24'h126000, 1'b0);
        do_load(1'b0, 24'h2A0000, 1'b0);

        alarm_en = 1'b1;
        do_load(1'b1, 24'h000005, 1'b1);
        do_load(1'b0, 24'h000000, 1'b1);
        run_int_ticks(4);
        check("alarm_pre", 48'(alarm_o), 48'd0);
        run_int_ticks(1);
        check("alarm_fire", 48'(alarm_o), 48'd1);
        run_int_ticks(2);
        check("alarm_hold", 48'(alarm_o), 48'd1);
        run_int_ticks(1);
        check("alarm_expire", 48'(alarm_o), 48'd0);

        do_load(1'b0, 24'h000000, 1'b1);
        run_int_ticks(5);
        check("alarm_fire2", 48'(alarm_o), 48'd1);
        alarm_ack = 1'b1;
        cyc();
        alarm_ack = 1'b0;
        @(negedge clk);
        check("alarm_ack", 48'(alarm_o), 48'd0);

        do_load(1'b0, 24'h000005, 1'b1);
        check("load_eq_no_fire", 48'(alarm_o), 48'd0);

        do_load(1'b0, 24'h000004, 1'b1);
        run_int_ticks(1);
        check("alarm_fire3", 48'(alarm_o), 48'd1);
        alarm_en = 1'b0;
        cyc();
        @(negedge clk);
        check("alarm_en_clear", 48'(alarm_o), 48'd0);
        alarm_en = 1'b1;

        tick_sel = 1'b0;
        repeat (3) cyc();
        cfg_sel = 1'b0;
        cfg = 24'h101010;
        dvalid = 1'b1;
        cyc();
        dvalid = 1'b0;
        tick_sel = 1'b1;
        model_time = 24'h101010;
        @(negedge clk);
        check("wrap_load_time", 48'(time_o), 48'h101010);
        check("wrap_load_no_tick", 48'(sec_tick_o), 48'd0);
        run_int_ticks(1);

        tick_sel = 1'b0;
        repeat (2) cyc();
        cfg = 24'h111111;
        dvalid = 1'b1;
        cyc();
        dvalid = 1'b0;
        tick_sel = 1'b1;
        model_time = 24'h111111;
        run_int_ticks(1);

        ext_edge();
        ext_edge();

        do_load(1'b1, model_inc(model_time), 1'b1);
        ext_edge();
        check("ext_alarm_fire", 48'(alarm_o), 48'd1);
        ext_tick = 1'b1;
        cyc();
        rst_ni = 1'b0;
        ext_tick = 1'b0;
        cyc();
        rst_ni = 1'b1;
        exp_q.delete();
        model_time = 24'h0;
        @(negedge clk);
        check("midrst_time", 48'(time_o), 48'h0);
        check("midrst_alarm", 48'(alarm_o), 48'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge clk);
            check("midrst_no_tick", 48'(sec_tick_o), 48'd0);
        end

        check("queue_empty", 48'(exp_q.size()), 48'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/asic_watch_gen.md
Name: asic_watch_gen

Overview:
- Parametrised successor to the 4-digit HH:MM watch core.
- BCD timekeeper with a seconds field (optionally displayed), an internal or external tick source, a loadable alarm with timed auto-clear, and BCD readback.
- Sits behind the user-project wrapper: load words come from the wishbone data bus, tick/select controls from IO/LA, 7-segment outputs drive io_out pads.

Parameters:
- CLK_DIV, 32768: sysclk_i cycles per second for the internal tick (≥2).
- SECONDS_EN, 1: 1 = 6 displayed digits HH:MM:SS; 0 = 4 digits HH:MM (seconds still counted internally).
- SEG_ACTIVE_LOW, 0: 1 inverts every segment output bit.
- ALARM_SECS, 60: seconds alarm_o stays high without ack (1..255).

Ports:
- sysclk_i, in, 1: single clock.
- rst_ni, in, 1: synchronous active-low reset.
- tick_sel_i, in, 1: 0 = internal divider; 1 = external 1 Hz pulse on ext_tick_i.
- ext_tick_i, in, 1: asynchronous external 1 Hz square/pulse.
- dvalid_i, in, 1: one-cycle load strobe.
- cfg_sel_i, in, 1: 0 = load time; 1 = load alarm.
- cfg_i, in, 24: BCD {hh[23:16], mm[15:8], ss[7:0]}.
- alarm_en_i, in, 1: alarm arm.
- alarm_ack_i, in, 1: clears alarm_o.
- seg_o, out, 7*NDIG (NDIG = SECONDS_EN ? 6 : 4): most significant digit at top; each digit is {g,f,e,d,c,b,a}.
- time_o, out, 24: current BCD time.
- sec_tick_o, out, 1: one-cycle pulse per counted second.
- alarm_o, out, 1: alarm active.
- load_err_o, out, 1: one-cycle pulse on a rejected load.

Behaviour:
- Reset values (rst_ni low at a clock edge): time 00:00:00, alarm register 00:00:00, divider 0, ext-sync flops 0, sec_tick_o 0, alarm_o 0, load_err_o 0, alarm hold counter 0.
- Reset output value: seg_o shows "0" in every digit (7'h3F per digit, inverted if SEG_ACTIVE_LOW).

Tick generation:
- Internal: divider counts 0..CLK_DIV-1; tick on the cycle it wraps from CLK_DIV-1 to 0.
- External: ext_tick_i goes through a 2-flop synchroniser plus a rising-edge detect; tick = detected edge, 3-cycle latency from input edge.
- Divider runs only while tick_sel_i = 0 and holds its value otherwise.
- Switching tick_sel_i produces no spurious tick. The edge-detect history flop updates regardless of tick_sel_i.

Counting:
- On a tick: ss+1, wrapping 59 -> 00 with carry to mm; mm 59 -> 00 with carry to hh; hh 23 -> 00.
- 23:59:59 -> 00:00:00 in a single tick.
- BCD nibbles are stored per digit; the ones digit carries at 9.
- sec_tick_o asserts in the cycle after the tick, aligned with the updated time_o.

Load:
- On dvalid_i, validate cfg_i: every nibble ≤ 9, hh ≤ 23, mm ≤ 59, ss ≤ 59.
- Valid load: write the target register (time or alarm) at the next edge.
- Valid time load also clears the divider to 0.
- Invalid load: registers unchanged; load_err_o pulses the next cycle.
- Time load and tick in the same cycle: load wins, tick is dropped, no sec_tick_o.

Alarm:
- Fires only when a tick-driven increment makes time equal the alarm register and alarm_en_i = 1.
- A time load that equals the alarm does not fire it.
- On fire: alarm_o = 1 next cycle; hold counter = ALARM_SECS.
- Each subsequent tick decrements the hold counter; alarm_o clears when it reaches 0.
- alarm_ack_i clears alarm_o immediately at the next edge.
- Ack and fire in the same cycle: fire wins.
- Deasserting alarm_en_i clears alarm_o at the next edge.

Display:
- Combinational BCD-to-7-segment from the time registers, 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
- Digit order hh, mm[, ss].

Reset mid-operation:
- Any rst_ni low edge returns every register to its reset value, including a pending external edge and an active alarm.

Test Plan:
- Reset then CLK_DIV=4, tick_sel_i=0, run 4 cycles -> time_o 00:00:01, one sec_tick_o pulse, seg_o low digit = 7'h06.
- Load 23:59:58 then 2 ticks -> 23:59:59, then 00:00:00; seg_o all 7'h3F.
- Load 12:60:00 and 2A:00:00 -> load_err_o pulses once per load; time_o unchanged.
- Alarm 00:00:05, alarm_en_i=1, ALARM_SECS=3 -> alarm_o high after 5th tick, low after 3 more ticks.
  - Repeat with alarm_ack_i at fire+1 -> low next cycle.
- Time load strobed on the same cycle as the divider wrap -> loaded value held, divider = 0, no sec_tick_o.
- tick_sel_i=1, ext_tick_i toggles 2 times -> 2 ticks, each 3 cycles after the rising edge.
  - rst_ni pulsed low mid-sequence -> time 00:00:00 and alarm_o 0.
